axi_lite_initiator: RTL
=======================

# axi_lite_initiator

AXI-Lite manager that converts a simple single-command request/response port into AXI-Lite write and read transactions. It drives the subordinate side of `axi_sram_controller` (or any AXI-Lite subordinate) and is the initiator used by pattern generators, display fetch logic and the SRAM test harness. It allows one transaction in flight, with full valid/ready compliance on all five AXI-Lite channels.

## Interface
- `AXI_ADDR_WIDTH`, 20: address width of the command port and the AW/AR channels.
- `AXI_DATA_WIDTH`, 16: data width of the command and response ports and the W/R channels; must be a multiple of 8.
- `axi_aclk`  in  1  sole clock; all logic is on the rising edge.
- `axi_aresetn`  in  1  reset, asynchronous and active-low.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted this cycle when high together with `cmd_valid`.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  AXI_ADDR_WIDTH  transaction address.
- `cmd_wdata`  in  AXI_DATA_WIDTH  write data; ignored for reads.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  response consumed.
- `rsp_we`  out  1  echoes `cmd_we` of the completed command.
- `rsp_rdata`  out  AXI_DATA_WIDTH  read data; 0 for writes.
- `rsp_resp`  out  2  BRESP or RRESP of the completed transaction.
- `m_axi_awaddr`/`awvalid`/`awready`: out AXI_ADDR_WIDTH, out 1, in 1.
- `m_axi_wdata`/`wstrb`/`wvalid`/`wready`: out AXI_DATA_WIDTH, out AXI_DATA_WIDTH/8, out 1, in 1.
- `m_axi_bresp`/`bvalid`/`bready`: in 2, in 1, out 1.
- `m_axi_araddr`/`arvalid`/`arready`: out AXI_ADDR_WIDTH, out 1, in 1.
- `m_axi_rdata`/`rresp`/`rvalid`/`rready`: in AXI_DATA_WIDTH, in 2, in 1, out 1.

## Operation
- States: IDLE, WR (AW/W outstanding), WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: `cmd_ready`=1. On `cmd_valid`, latch addr/data/we. A write goes to WR with `awvalid`=`wvalid`=1. A read goes to RD_ADDR with `arvalid`=1.
- WR: AW and W complete independently. `awvalid` drops the cycle after its own handshake, and `wvalid` likewise. Both may complete in the same cycle, or in either order. When both are done, go to WR_RESP.
- WR_RESP: `bready`=1. On `bvalid`, capture `bresp` and go to RSP.
- RD_ADDR: on `arready`, drop `arvalid` and go to RD_DATA.
- RD_DATA: `rready`=1. On `rvalid`, capture `rdata`/`rresp` and go to RSP.
- RSP: `rsp_valid`=1 and response registers are stable. On `rsp_ready`, go to IDLE.
- `wstrb` is all ones for every write.
- Once a valid is raised, it is never withdrawn before its handshake, and the address/data stay stable until then.
- Non-OKAY responses are passed through unchanged in `rsp_resp`. There are no retries.
- Address, data and strobe outputs hold their last value when their valid is low.

## Timing
- Reset (asynchronous assert, synchronous release) drives all valids, readies and `rsp_valid` to 0, and addr/data/rdata/resp/rsp_we to 0. The FSM goes to IDLE. `cmd_ready` is 1 from the first clock after release.
- Reset asserted mid-transaction abandons it immediately. All outputs return to reset values, with no completion of the pending handshake.
- A command is accepted on edge N. Then `awvalid`/`wvalid` (or `arvalid`) are high from N+1, registered.
- With a zero-wait subordinate (readies high, response one cycle after the address/data handshake), a write gives `rsp_valid` at N+4 and a read at N+4.
- `rsp_valid` rises the cycle after the B/R handshake.
- `bready`/`rready` are high only in their response states. They are 0 at every other time.
- A new command is accepted no earlier than the cycle after `rsp_valid`&&`rsp_ready`, because `cmd_ready` is 0 outside IDLE.
- Throughput is at most one transaction per 5 cycles.
- All outputs are registered; there are no combinational paths from AXI inputs to AXI outputs.

## Test plan
- Reset check: hold `axi_aresetn`=0 for 3 cycles, then release → all valids/readies 0, `cmd_ready`=1, `rsp_valid`=0.
- Write to `axi_sram_controller` + `sram_model` (ADDR 10, DATA 8): cmd write 0x0A1←0x5C, `rsp_ready`=1 → exactly one AW and one W handshake with awaddr 0x0A1, wdata 0x5C, wstrb 1; `rsp_valid` with `rsp_resp`=0; SRAM[0x0A1]=0x5C.
- Read-back: read 0x0A1 after the previous write → `rsp_rdata`=0x5C, `rsp_resp`=0, `rsp_we`=0.
- Skewed write handshakes against a stub subordinate: `wready` high at cycle 1 and `awready` high 4 cycles later → `wvalid` drops after 1 cycle; `awvalid` is held with stable addr until its handshake; `bready` rises only after both.
- Backpressure: rsp stub returns `rresp`=2'b10, rdata 0xEE; hold `rsp_ready`=0 for 6 cycles → `rsp_valid` stays high with data stable and `cmd_ready` 0, then returns to IDLE one cycle after `rsp_ready`.
- Mid-operation reset: assert reset while in WR_RESP with `bvalid` low → `bready` and all valids 0 asynchronously; the next command after release completes normally.

Source files
------------

// File: rtl/axi_lite_initiator.sv
// axi_lite_initiator: single-outstanding AXI-Lite manager. Converts a
// command/response handshake into one AXI-Lite write (AW+W+B) or read (AR+R).
// Every output is driven from a flop, so no AXI input reaches an AXI output
// combinationally.
module axi_lite_initiator #(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                        axi_aclk,
    input  logic                        axi_aresetn,
    // command / response port
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic                        cmd_we,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_we,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                  rsp_resp,
    // AXI-Lite write address / data / response
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic                        m_axi_awvalid,
    input  logic                        m_axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
    output logic                        m_axi_wvalid,
    input  logic                        m_axi_wready,
    input  logic [1:0]                  m_axi_bresp,
    input  logic                        m_axi_bvalid,
    output logic                        m_axi_bready,
    // AXI-Lite read address / data
    output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic                        m_axi_arvalid,
    input  logic                        m_axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]                  m_axi_rresp,
    input  logic                        m_axi_rvalid,
    output logic                        m_axi_rready
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_WR_RESP = 3'd2;
    localparam logic [2:0] S_RD_ADDR = 3'd3;
    localparam logic [2:0] S_RD_DATA = 3'd4;
    localparam logic [2:0] S_RSP     = 3'd5;

    logic [2:0]                state_q,     state_d;
    logic                      cmd_ready_q, cmd_ready_d;
    logic                      awvalid_q,   awvalid_d;
    logic                      wvalid_q,    wvalid_d;
    logic                      arvalid_q,   arvalid_d;
    logic                      bready_q,    bready_d;
    logic                      rready_q,    rready_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic                      rsp_we_q,    rsp_we_d;
    logic [AXI_ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
    logic [AXI_ADDR_WIDTH-1:0] araddr_q,    araddr_d;
    logic [AXI_DATA_WIDTH-1:0] wdata_q,     wdata_d;
    logic [STRB_W-1:0]         wstrb_q,     wstrb_d;
    logic [AXI_DATA_WIDTH-1:0] rdata_q,     rdata_d;
    logic [1:0]                resp_q,      resp_d;

    // Next-state logic: FSM plus per-channel valid/ready and capture registers.
    always_comb begin
        state_d     = state_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        resp_d      = resp_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    rsp_we_d = cmd_we;
                    if (cmd_we) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = '1;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = S_WR;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = S_RD_ADDR;
                    end
                end
            end
            S_WR: begin
                // AW and W retire independently; leave once neither is pending.
                if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bready_q && m_axi_bvalid) begin
                    resp_d      = m_axi_bresp;
                    rdata_d     = '0;
                    bready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (arvalid_q && m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rready_q && m_axi_rvalid) begin
                    rdata_d     = m_axi_rdata;
                    resp_d      = m_axi_rresp;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered cmd_ready: high only while resting in IDLE, so a
        // command is never taken in the same cycle as a response drains.
        cmd_ready_d = (state_d == S_IDLE);
    end

    // State registers; reset abandons any in-flight transaction at once.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q     <= S_IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            resp_q      <= resp_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_we        = rsp_we_q;
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
